lenet_c3_sched: RTL and testbench

Job scheduler for the C3 5x5 convolution engine. It walks every (output map, input channel) pair of a partially connected layer and skips pairs that have no connection. For each connected pair it copies the 25 kernel weights from a synchronous weight memory into the engine's weight-load port. It then requests one input-frame pass from the feature-map streamer and flags first/last channel to the partial-sum accumulator. It sits between the layer controller, the weight memory, the conv engine and the streamer.

---
 rtl/lenet_c3_sched.sv | 176 +++++++++++++++++
 tb/tb_lenet_c3_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_c3_sched.sv
// Job scheduler for the LeNet C3 5x5 convolution engine.
// Walks every (output map, input channel) pair of the connection mask,
// skips unconnected pairs, streams 25 kernel weights from the weight memory
// into the engine, then requests one input-frame pass and waits for it.
module lenet_c3_sched #(
  parameter int WW    = 8,
  parameter int N_IN  = 6,
  parameter int N_OUT = 16,
  parameter int MA    = 12
) (
  input  logic                   i_sclk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [N_IN*N_OUT-1:0]  i_conn,
  output logic                   o_wm_rd,
  output logic [MA-1:0]          o_wm_addr,
  input  logic [WW-1:0]          i_wm_data,
  output logic                   o_W_en,
  output logic [4:0]             o_W_addr,
  output logic [WW-1:0]          o_Weight,
  output logic                   o_frm_req,
  input  logic                   i_frm_done,
  output logic [4:0]             o_out_idx,
  output logic [2:0]             o_in_idx,
  output logic                   o_acc_first,
  output logic                   o_acc_last,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int         PW     = $clog2(N_IN*N_OUT);
  localparam logic [4:0] K_LAST = 5'd25;   // one past the last kernel tap

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_LOAD, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [N_IN*N_OUT-1:0] r_conn;
  logic [4:0]            r_o;
  logic [2:0]            r_c;
  logic [4:0]            r_k;
  logic                  r_wen;
  logic [4:0]            r_waddr;

  logic [PW-1:0]         w_rbase;
  logic [PW-1:0]         w_pidx;
  logic [N_IN-1:0]       w_row;
  logic                  w_bit;
  logic                  w_last_pair;
  logic                  w_rd;
  logic [MA-1:0]         w_pair;
  logic [MA-1:0]         w_addr;
  logic                  w_first;
  logic                  w_last;
  logic                  w_in_job;

  // Mask lookup for the current pair and its output-map row.
  assign w_rbase     = PW'(r_o) * PW'(N_IN);
  assign w_pidx      = w_rbase + PW'(r_c);
  assign w_row       = r_conn[w_rbase +: N_IN];
  assign w_bit       = r_conn[w_pidx];
  assign w_last_pair = (r_o == 5'(N_OUT-1)) && (r_c == 3'(N_IN-1));

  // Dense weight layout: every pair owns 25 slots whether connected or not.
  assign w_pair = MA'(r_o) * MA'(N_IN) + MA'(r_c);
  assign w_addr = w_pair * MA'(25) + MA'(r_k);
  assign w_rd   = (r_state == S_LOAD) && (r_k < K_LAST);

  // State register.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_next; otherwise a latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_start) w_next = S_SCAN;
      S_SCAN: begin
        if (w_bit)            w_next = S_LOAD;
        else if (w_last_pair) w_next = S_DONE;
      end
      S_LOAD: if (r_k == K_LAST) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: if (i_frm_done) w_next = w_last_pair ? S_DONE : S_SCAN;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pair walker, kernel tap counter and latched mask.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rstn) begin
      r_conn <= '0;
      r_o    <= '0;
      r_c    <= '0;
      r_k    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_conn <= i_conn;
            r_o    <= '0;
            r_c    <= '0;
          end
        end
        S_SCAN: begin
          if (w_bit) begin
            r_k <= '0;
          end else if (!w_last_pair) begin
            if (r_c == 3'(N_IN-1)) begin
              r_c <= '0;
              r_o <= r_o + 5'd1;
            end else begin
              r_c <= r_c + 3'd1;
            end
          end
        end
        S_LOAD: r_k <= r_k + 5'd1;
        S_WAIT: begin
          if (i_frm_done && !w_last_pair) begin
            if (r_c == 3'(N_IN-1)) begin
              r_c <= '0;
              r_o <= r_o + 5'd1;
            end else begin
              r_c <= r_c + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Engine write follows each memory read by one cycle, when data returns.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
    end else begin
      r_wen   <= w_rd;
      r_waddr <= r_k;
    end
  end

  // Accumulator first/last flags from the latched row of the current map.
  always_comb begin
    w_first = w_row[r_c];
    w_last  = w_row[r_c];
    for (int i = 0; i < N_IN; i++) begin
      if (i < int'(r_c) && w_row[i]) w_first = 1'b0;
      if (i > int'(r_c) && w_row[i]) w_last  = 1'b0;
    end
  end

  assign w_in_job    = (r_state == S_LOAD) || (r_state == S_REQ) || (r_state == S_WAIT);

  assign o_wm_rd     = w_rd;
  assign o_wm_addr   = w_rd ? w_addr : '0;
  assign o_W_en      = r_wen;
  assign o_W_addr    = r_wen ? r_waddr : '0;
  assign o_Weight    = r_wen ? i_wm_data : '0;
  assign o_frm_req   = (r_state == S_REQ);
  assign o_out_idx   = r_o;
  assign o_in_idx    = r_c;
  assign o_acc_first = w_in_job && w_first;
  assign o_acc_last  = w_in_job && w_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_lenet_c3_sched.sv
// Directed testbench for lenet_c3_sched: weight-memory and streamer models,
// a negedge monitor that logs reads, writes, frames and done pulses, and one
// task per scenario comparing the logs with hand-computed expectations.
module tb_lenet_c3_sched;

  localparam int WW = 8, N_IN = 6, N_OUT = 16, MA = 12;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_start;
  logic [N_IN*N_OUT-1:0] i_conn;
  logic                  o_wm_rd;
  logic [MA-1:0]         o_wm_addr;
  logic [WW-1:0]         i_wm_data;
  logic                  o_W_en;
  logic [4:0]            o_W_addr;
  logic [WW-1:0]         o_Weight;
  logic                  o_frm_req;
  logic                  i_frm_done;
  logic [4:0]            o_out_idx;
  logic [2:0]            o_in_idx;
  logic                  o_acc_first, o_acc_last, o_busy, o_done;

  logic strm_done, spur_done;
  assign i_frm_done = strm_done | spur_done;

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  typedef struct packed {
    logic [4:0] o;
    logic [2:0] c;
    logic       first;
    logic       last;
  } frame_t;

  // Monitor logs
  logic [MA-1:0] addr_q[$];
  frame_t        frames[$];
  int n_wen, n_done, wr_err;
  int first_rd_cyc, first_wen_cyc, req_cyc, done_cyc;
  logic          prev_rd;
  logic [4:0]    prev_k;
  logic [MA-1:0] prev_addr;

  lenet_c3_sched #(.WW(WW), .N_IN(N_IN), .N_OUT(N_OUT), .MA(MA)) dut (
    .i_sclk(clk), .i_rstn(rst_n), .i_start(i_start), .i_conn(i_conn),
    .o_wm_rd(o_wm_rd), .o_wm_addr(o_wm_addr), .i_wm_data(i_wm_data),
    .o_W_en(o_W_en), .o_W_addr(o_W_addr), .o_Weight(o_Weight),
    .o_frm_req(o_frm_req), .i_frm_done(i_frm_done),
    .o_out_idx(o_out_idx), .o_in_idx(o_in_idx),
    .o_acc_first(o_acc_first), .o_acc_last(o_acc_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [MA-1:0] a);
    return a[7:0] ^ {4'h0, a[11:8]} ^ 8'h5A;
  endfunction

  // Cycle counter: value after a rising edge names the cycle that follows.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Synchronous weight memory: data valid one cycle after the read strobe.
  initial begin
    logic          rd;
    logic [MA-1:0] a;
    i_wm_data = 8'hEE;
    forever begin
      @(negedge clk);
      rd = o_wm_rd;
      a  = o_wm_addr;
      @(posedge clk);
      #1 i_wm_data = rd ? mem_f(a) : 8'hEE;
    end
  end

  // Streamer: acknowledge 10 cycles after each frame request.
  initial begin
    strm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_frm_req) begin
        repeat (10) @(posedge clk);
        #1 strm_done = 1'b1;
        @(posedge clk);
        #1 strm_done = 1'b0;
      end
    end
  end

  // Monitor sampled on the falling edge.
  initial forever begin
    logic [4:0] k_now;
    @(negedge clk);
    k_now = 5'd0;
    if (o_W_en) begin
      n_wen++;
      if (first_wen_cyc < 0) first_wen_cyc = cyc;
      if (!prev_rd || o_W_addr !== prev_k || o_Weight !== mem_f(prev_addr)) wr_err++;
    end
    if (o_wm_rd) begin
      addr_q.push_back(o_wm_addr);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      k_now = prev_rd ? prev_k + 5'd1 : 5'd0;
    end
    prev_rd   = o_wm_rd;
    prev_k    = k_now;
    prev_addr = o_wm_addr;
    if (o_frm_req) begin
      frames.push_back('{o: o_out_idx, c: o_in_idx, first: o_acc_first, last: o_acc_last});
      if (req_cyc < 0) req_cyc = cyc;
    end
    if (o_done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    addr_q.delete();
    frames.delete();
    n_wen = 0; n_done = 0; wr_err = 0;
    first_rd_cyc = -1; first_wen_cyc = -1; req_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_run(input logic [N_IN*N_OUT-1:0] mask, output int c0);
    @(posedge clk);
    #1;
    i_conn  = mask;
    i_start = 1'b1;
    c0      = cyc;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("FAIL %s_timeout: o_done not seen within %0d cycles", name, budget);
    else n_pass++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_conn = '0; spur_done = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if ({o_wm_rd, o_wm_addr, o_W_en, o_W_addr, o_Weight} !== '0)
      $display("FAIL reset_wr_outs: got %h want 0", {o_wm_rd, o_wm_addr, o_W_en, o_W_addr, o_Weight});
    else n_pass++;
    n_total++;
    if ({o_frm_req, o_out_idx, o_in_idx, o_acc_first, o_acc_last, o_busy, o_done} !== '0)
      $display("FAIL reset_ctl_outs: got %h want 0",
               {o_frm_req, o_out_idx, o_in_idx, o_acc_first, o_acc_last, o_busy, o_done});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_all_zero();
    int c0;
    clear_mon();
    start_run('0, c0);
    wait_done(200, "zero");
    n_total++;
    if (addr_q.size() !== 0) $display("FAIL zero_reads: got %0d want 0", addr_q.size());
    else n_pass++;
    n_total++;
    if (frames.size() !== 0) $display("FAIL zero_frames: got %0d want 0", frames.size());
    else n_pass++;
    // Start cycle, 96 SCAN cycles, then DONE: o_done lands 97 cycles after the start cycle.
    n_total++;
    if (done_cyc - c0 !== 97) $display("FAIL zero_done_lat: got %0d want 97", done_cyc - c0);
    else n_pass++;
    n_total++;
    if (n_done !== 1) $display("FAIL zero_done_cnt: got %0d want 1", n_done);
    else n_pass++;
  endtask

  task automatic check_single(input string name, input int c0);
    int err = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== MA'(500 + i)) err++;
    n_total++;
    if (addr_q.size() !== 25) $display("FAIL %s_nreads: got %0d want 25", name, addr_q.size());
    else n_pass++;
    n_total++;
    if (err !== 0) $display("FAIL %s_addr_seq: got %0d bad addrs want 0", name, err);
    else n_pass++;
    n_total++;
    if (n_wen !== 25 || wr_err !== 0)
      $display("FAIL %s_writes: got %0d writes %0d bad want 25/0", name, n_wen, wr_err);
    else n_pass++;
    // Pair (3,2) is index 20: SCAN finds it at c0+21.
    n_total++;
    if (first_rd_cyc - c0 !== 22) $display("FAIL %s_rd_lat: got %0d want 22", name, first_rd_cyc - c0);
    else n_pass++;
    n_total++;
    if (first_wen_cyc - c0 !== 23) $display("FAIL %s_wen_lat: got %0d want 23", name, first_wen_cyc - c0);
    else n_pass++;
    n_total++;
    if (req_cyc - c0 !== 48) $display("FAIL %s_req_lat: got %0d want 48", name, req_cyc - c0);
    else n_pass++;
    n_total++;
    if (frames.size() !== 1) $display("FAIL %s_nframes: got %0d want 1", name, frames.size());
    else n_pass++;
    if (frames.size() > 0) begin
      n_total++;
      if (frames[0] !== frame_t'{o: 5'd3, c: 3'd2, first: 1'b1, last: 1'b1})
        $display("FAIL %s_frame: got %h want %h", name, frames[0],
                 frame_t'{o: 5'd3, c: 3'd2, first: 1'b1, last: 1'b1});
      else n_pass++;
    end
    // Ack at c0+58, then SCAN (3,3)..(15,5) = 75 cycles, DONE at c0+134.
    n_total++;
    if (done_cyc - c0 !== 134 || n_done !== 1)
      $display("FAIL %s_done: got lat %0d cnt %0d want 134/1", name, done_cyc - c0, n_done);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [N_IN*N_OUT-1:0] m = '0;
    int c0;
    m[3*N_IN + 2] = 1'b1;
    clear_mon();
    start_run(m, c0);
    wait_done(400, "single");
    check_single("single", c0);
  endtask

  task automatic test_spurious();
    logic [N_IN*N_OUT-1:0] m = '0;
    int c0;
    m[3*N_IN + 2] = 1'b1;
    clear_mon();
    start_run(m, c0);
    for (int i = 0; i < 100 && first_rd_cyc < 0; i++) @(negedge clk);
    // Inject a start with a different mask and stray frame-done pulses mid-LOAD.
    @(posedge clk);
    #1; i_conn = '1; i_start = 1'b1; spur_done = 1'b1;
    @(posedge clk);
    #1; i_start = 1'b0; spur_done = 1'b0;
    repeat (5) @(posedge clk);
    #1; spur_done = 1'b1; i_start = 1'b1;
    @(posedge clk);
    #1; spur_done = 1'b0; i_start = 1'b0;
    wait_done(400, "spur");
    check_single("spur", c0);
  endtask

  task automatic test_all_ones(input string name);
    int c0;
    int err_a = 0, err_f = 0;
    clear_mon();
    start_run('1, c0);
    wait_done(5000, name);
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== MA'(i)) err_a++;
    for (int i = 0; i < frames.size(); i++)
      if (frames[i].o !== 5'(i / 6) || frames[i].c !== 3'(i % 6) ||
          frames[i].first !== (i % 6 == 0) || frames[i].last !== (i % 6 == 5)) err_f++;
    n_total++;
    if (frames.size() !== 96) $display("FAIL %s_nframes: got %0d want 96", name, frames.size());
    else n_pass++;
    n_total++;
    if (addr_q.size() !== 2400 || err_a !== 0)
      $display("FAIL %s_addr: got %0d reads %0d bad want 2400/0", name, addr_q.size(), err_a);
    else n_pass++;
    n_total++;
    if (err_f !== 0) $display("FAIL %s_flags: got %0d bad frames want 0", name, err_f);
    else n_pass++;
    n_total++;
    if (n_wen !== 2400 || wr_err !== 0)
      $display("FAIL %s_writes: got %0d writes %0d bad want 2400/0", name, n_wen, wr_err);
    else n_pass++;
    n_total++;
    if (n_done !== 1) $display("FAIL %s_done_cnt: got %0d want 1", name, n_done);
    else n_pass++;
  endtask

  task automatic test_lenet();
    logic [N_IN-1:0]       rows[16] = '{6'b000111, 6'b001110, 6'b011100, 6'b111000,
                                        6'b110001, 6'b100011, 6'b001111, 6'b011110,
                                        6'b111100, 6'b111001, 6'b110011, 6'b100111,
                                        6'b011011, 6'b110110, 6'b101101, 6'b111111};
    int                    lo[16] = '{0,1,2,3,0,0,0,1,2,0,0,0,0,1,0,0};
    int                    hi[16] = '{2,3,4,5,5,5,3,4,5,5,5,5,4,5,5,5};
    logic [N_IN*N_OUT-1:0] m;
    logic [MA-1:0]         exp_a[$];
    frame_t                exp_f[$];
    int c0, err_a = 0, err_f = 0;
    for (int o = 0; o < 16; o++) begin
      m[o*N_IN +: N_IN] = rows[o];
      for (int c = 0; c < N_IN; c++)
        if (rows[o][c]) begin
          exp_f.push_back('{o: 5'(o), c: 3'(c), first: (c == lo[o]), last: (c == hi[o])});
          for (int k = 0; k < 25; k++) exp_a.push_back(MA'((o*6 + c)*25 + k));
        end
    end
    clear_mon();
    start_run(m, c0);
    wait_done(4000, "lenet");
    for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++) if (addr_q[i] !== exp_a[i]) err_a++;
    for (int i = 0; i < exp_f.size() && i < frames.size(); i++) if (frames[i] !== exp_f[i]) err_f++;
    n_total++;
    if (frames.size() !== 60) $display("FAIL lenet_nframes: got %0d want 60", frames.size());
    else n_pass++;
    n_total++;
    if (err_f !== 0) $display("FAIL lenet_frames: got %0d bad want 0", err_f);
    else n_pass++;
    n_total++;
    if (addr_q.size() !== 1500 || err_a !== 0)
      $display("FAIL lenet_addr: got %0d reads %0d bad want 1500/0", addr_q.size(), err_a);
    else n_pass++;
    n_total++;
    if (n_wen !== 1500 || wr_err !== 0)
      $display("FAIL lenet_writes: got %0d writes %0d bad want 1500/0", n_wen, wr_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int c0;
    clear_mon();
    start_run('1, c0);
    for (int i = 0; i < 200 && req_cyc < 0; i++) @(negedge clk);
    n_total++;
    if (req_cyc < 0) $display("FAIL rstw_req_timeout: got none want a request");
    else n_pass++;
    repeat (3) @(posedge clk);
    #3;
    n_total++;
    if ({o_busy, o_acc_first, o_frm_req} !== 3'b110)
      $display("FAIL rstw_pre: got %b want 110", {o_busy, o_acc_first, o_frm_req});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_busy, o_W_en, o_frm_req, o_wm_rd, o_acc_first, o_acc_last, o_done, o_out_idx, o_in_idx} !== '0)
      $display("FAIL rstw_outs: got %h want 0",
               {o_busy, o_W_en, o_frm_req, o_wm_rd, o_acc_first, o_acc_last, o_done, o_out_idx, o_in_idx});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    test_all_ones("rstw_rerun");
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single();
    test_all_ones("ones");
    test_lenet();
    test_spurious();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
